mat_stream_loader: RTL

MAT_STREAM_LOADER -- requirements
Module: mat_stream_loader

---
 rtl/mat_stream_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mat_stream_loader.sv
// mat_stream_loader: streams N_OPER operand bytes into a small scratch memory, pulses start
//   to the compute core, waits for done (with timeout), then streams N_OPER result bytes out.
// Latency: operand writes are combinational with the input handshake. Each result byte takes
//   one READ cycle plus at least one SEND cycle.
// Backpressure: in_ready drops once the last operand is accepted and stays low until the loader
//   is back in IDLE. out_valid/out_data hold stable while out_ready is low.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_data/in_ready       operand byte stream in
//   mem_we/mem_addr/mem_wdata       scratch memory write/read port
//   mem_rdata                       read data, sampled one cycle after mem_addr is presented
//   start/done                      compute core handshake
//   out_valid/out_data/out_ready    result byte stream out
//   busy, timeout_err               status; timeout_err is sticky until the next load begins
module mat_stream_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int N_OPER   = 8,
  parameter int RES_BASE = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              start,
  input  logic              done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W  = (N_OPER > 1) ? $clog2(N_OPER) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_READ  = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  load_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic load_phase;
  logic in_hs;
  logic out_hs;
  logic load_last;
  logic rd_last;
  logic wait_last;

  // The input side is only open while loading and never while reset is held, so no operand
  // write can slip through during reset.
  assign load_phase = ((state == S_IDLE) || (state == S_LOAD)) && !reset;
  assign in_hs      = in_valid && load_phase;
  assign out_hs     = out_ready && (state == S_SEND);
  assign load_last  = (load_cnt == CNT_W'(N_OPER - 1));
  assign rd_last    = (rd_cnt == CNT_W'(N_OPER - 1));
  assign wait_last  = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_LOAD: begin
        if (in_hs) begin
          state_nxt = load_last ? S_START : S_LOAD;
        end
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (done) begin
          state_nxt = S_READ;
        end else if (wait_last) begin
          state_nxt = S_IDLE;
        end
      end
      S_READ: state_nxt = S_SEND;
      S_SEND: begin
        if (out_hs) begin
          state_nxt = rd_last ? S_IDLE : S_READ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters, result capture and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt    <= '0;
      rd_cnt      <= '0;
      wait_cnt    <= '0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_hs) begin
            load_cnt <= load_cnt + CNT_W'(1);
            if (state == S_IDLE) begin
              timeout_err <= 1'b0;
            end
          end
        end
        S_START: wait_cnt <= '0;
        S_WAIT: begin
          if (done) begin
            rd_cnt <= '0;
          end else if (wait_last) begin
            timeout_err <= 1'b1;
            load_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        // Address was presented during READ; the memory answers by the end of this cycle.
        S_READ: out_data <= mem_rdata;
        S_SEND: begin
          if (out_hs) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_last) begin
              load_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    start     = 1'b0;
    out_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE, S_LOAD: begin
        in_ready = load_phase;
        mem_we   = in_hs;
        mem_addr = ADDR_W'(load_cnt);
        if (in_hs) begin
          mem_wdata = in_data;
        end
      end
      S_START: start = 1'b1;
      // Result address wraps within the memory if RES_BASE + N_OPER exceeds it.
      S_READ:  mem_addr = ADDR_W'(RES_BASE) + ADDR_W'(rd_cnt);
      S_SEND:  out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
